// File: rtl/ltc2324_axis_packer.sv
// ltc2324_axis_packer
// Packs each LTC2324-16 conversion (4 x 16-bit channels) into one 64-bit
// AXI4-Stream beat, buffers beats in a small FIFO, and frames them into
// fixed-length packets (tlast every PKT_LEN written beats) for an S2MM DMA.
// Samples lost to a full FIFO are counted in ovf_cnt (saturating).
//
// Optional build macro: LTC_AXIS_OVF_TUSER_EN
//   When defined, adds m_axis_tuser, which marks the first beat written after
//   one or more dropped samples.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   capture_en               1 = accept conversions, 0 = stop at packet boundary
//   adc_valid, adc_ch1..4    driver valid level and channel samples
//   m_axis_*                 AXI4-Stream master (tdata = {ch4,ch3,ch2,ch1})
//   busy                     FSM not idle
//   ovf_cnt                  dropped-sample count, saturating
//   pkt_cnt                  packets whose tlast beat was accepted, wrapping
module ltc2324_axis_packer #(
    parameter int unsigned PKT_LEN = 1024,
    parameter int unsigned FIFO_AW = 4,
    parameter int unsigned OVF_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             capture_en,
    input  logic             adc_valid,
    input  logic [15:0]      adc_ch1,
    input  logic [15:0]      adc_ch2,
    input  logic [15:0]      adc_ch3,
    input  logic [15:0]      adc_ch4,
    output logic [63:0]      m_axis_tdata,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic             m_axis_tlast,
    output logic [7:0]       m_axis_tkeep,
`ifdef LTC_AXIS_OVF_TUSER_EN
    output logic             m_axis_tuser,
`endif
    output logic             busy,
    output logic [OVF_W-1:0] ovf_cnt,
    output logic [15:0]      pkt_cnt
);

    localparam int unsigned DEPTH = 2 ** FIFO_AW;
    localparam int unsigned CNT_W = FIFO_AW + 1;
    localparam int unsigned IDX_W = 16;
`ifdef LTC_AXIS_OVF_TUSER_EN
    localparam int unsigned FW = 66;
`else
    localparam int unsigned FW = 65;
`endif

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t               state_q, state_d;
    logic                 adc_valid_d;
    logic [63:0]          hold_data;
    logic                 wr_req;
    logic [IDX_W-1:0]     beat_idx;
    logic [FW-1:0]        mem [DEPTH];
    logic [FIFO_AW-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]     count;
    logic [FW-1:0]        wr_word;
    logic                 fifo_full, fifo_empty;
    logic                 go_drain, cap_evt, wr_en, rd_en, is_last;
`ifdef LTC_AXIS_OVF_TUSER_EN
    logic                 ovf_flag;
`endif

    assign fifo_full  = (count == CNT_W'(DEPTH));
    assign fifo_empty = (count == '0);
    assign is_last    = (beat_idx == IDX_W'(PKT_LEN - 1));
    // Stop only at a packet boundary with nothing still waiting to be written.
    assign go_drain   = (state_q == RUN) && !capture_en && (beat_idx == '0) && !wr_req;
    // A rising edge in the cycle that leaves RUN does not open a new packet.
    assign cap_evt    = (state_q == RUN) && adc_valid && !adc_valid_d && !go_drain;
    assign wr_en      = wr_req && !fifo_full;
    assign rd_en      = !fifo_empty && (!m_axis_tvalid || m_axis_tready);
    assign m_axis_tkeep = 8'hFF;

`ifdef LTC_AXIS_OVF_TUSER_EN
    assign wr_word = {ovf_flag, is_last, hold_data};
`else
    assign wr_word = {is_last, hold_data};
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            busy    <= (state_d != IDLE);
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (capture_en) state_d = RUN;
            RUN:     if (go_drain) state_d = DRAIN;
            DRAIN:   if (fifo_empty && !m_axis_tvalid && !wr_req) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Edge detect, holding register, write side and overflow accounting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            adc_valid_d <= 1'b0;
            hold_data   <= '0;
            wr_req      <= 1'b0;
            beat_idx    <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            ovf_cnt     <= '0;
`ifdef LTC_AXIS_OVF_TUSER_EN
            ovf_flag    <= 1'b0;
`endif
        end else begin
            adc_valid_d <= adc_valid;
            wr_req      <= cap_evt;
            if (cap_evt) hold_data <= {adc_ch4, adc_ch3, adc_ch2, adc_ch1};

            // Index advances only on written beats so packets stay PKT_LEN long.
            if (state_q == IDLE) beat_idx <= '0;
            else if (wr_en) beat_idx <= is_last ? '0 : beat_idx + IDX_W'(1);

            if (wr_en) wr_ptr <= wr_ptr + FIFO_AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + FIFO_AW'(1);

            case ({wr_en, rd_en})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase

            if (wr_req && fifo_full && (ovf_cnt != {OVF_W{1'b1}}))
                ovf_cnt <= ovf_cnt + OVF_W'(1);

`ifdef LTC_AXIS_OVF_TUSER_EN
            if (wr_en) ovf_flag <= 1'b0;
            else if (wr_req && fifo_full) ovf_flag <= 1'b1;
`endif
        end
    end

    // FIFO storage (contents are don't-care while pointers are reset)
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_word;
    end

    // Output skid register and packet counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
`ifdef LTC_AXIS_OVF_TUSER_EN
            m_axis_tuser  <= 1'b0;
`endif
            pkt_cnt       <= '0;
        end else begin
            if (rd_en) begin
                m_axis_tvalid <= 1'b1;
`ifdef LTC_AXIS_OVF_TUSER_EN
                {m_axis_tuser, m_axis_tlast, m_axis_tdata} <= mem[rd_ptr];
`else
                {m_axis_tlast, m_axis_tdata} <= mem[rd_ptr];
`endif
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end

            if (m_axis_tvalid && m_axis_tready && m_axis_tlast)
                pkt_cnt <= pkt_cnt + 16'd1;
        end
    end

endmodule
